// File: rtl/p_clic_nest_if.sv
// p_clic_nest_if: groups the interrupt request lines, configuration, the
// claim/complete handshake and the arbitration results of p_clic_nest.
//   master : interrupt sources and the core (drives irq/config/take/complete)
//   slave  : the controller (drives is_interrupt/index/irq_prio/level/nest)
interface p_clic_nest_if #(
    parameter int NrSources = 4,
    parameter int PrioWidth = 3,
    parameter int Depth     = 4
);
    localparam int SrcWidth   = $clog2(NrSources);
    localparam int DepthWidth = $clog2(Depth + 1);

    logic [NrSources-1:0]  irq;
    logic [NrSources-1:0]  edge_mode;
    logic [NrSources-1:0]  e;
    logic [PrioWidth-1:0]  prio [NrSources];
    logic [PrioWidth-1:0]  t;
    logic                  take;
    logic                  complete;
    logic                  is_interrupt;
    logic [SrcWidth-1:0]   index;
    logic [PrioWidth-1:0]  irq_prio;
    logic [PrioWidth-1:0]  level;
    logic [DepthWidth-1:0] nest;

    modport master (
        output irq, edge_mode, e, prio, t, take, complete,
        input  is_interrupt, index, irq_prio, level, nest
    );

    modport slave (
        input  irq, edge_mode, e, prio, t, take, complete,
        output is_interrupt, index, irq_prio, level, nest
    );
endinterface

// File: rtl/p_clic_nest.sv
// p_clic_nest: nesting interrupt controller. Latches per-source requests
// (edge or level), presents the highest-priority enabled pending source
// above the current threshold, and keeps a priority stack driven by the
// core's claim (take) / complete handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : p_clic_nest_if slave (requests, config, handshake, result)

// Per-source pending latch with edge detection.
module p_clic_nest_src (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic edge_mode,
    input  logic clr,
    output logic pend
);
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
            pend  <= 1'b0;
        end else begin
            irq_q <= irq;
            if (!edge_mode)
                pend <= irq;
            else if (irq && !irq_q)
                pend <= 1'b1;   // a new edge beats a claim in the same cycle
            else if (clr)
                pend <= 1'b0;
        end
    end
endmodule

module p_clic_nest #(
    parameter int NrSources = 4,
    parameter int PrioWidth = 3,
    parameter int Depth     = 4
) (
    input  logic           clk,
    input  logic           reset,
    p_clic_nest_if.slave   bus
);
    localparam int SrcWidth   = $clog2(NrSources);
    localparam int DepthWidth = $clog2(Depth + 1);

    logic [NrSources-1:0]  pend;
    logic [NrSources-1:0]  clr;
    logic [PrioWidth-1:0]  stack [Depth];
    logic [DepthWidth-1:0] nest;
    logic [PrioWidth-1:0]  lvl;
    logic                  found;
    logic [SrcWidth-1:0]   win_idx;
    logic [PrioWidth-1:0]  win_prio;
    logic                  is_int;
    logic                  take_ok;
    logic                  comp_ok;

    for (genvar g = 0; g < NrSources; g++) begin : g_src
        p_clic_nest_src u_src (
            .clk       (clk),
            .reset     (reset),
            .irq       (bus.irq[g]),
            .edge_mode (bus.edge_mode[g]),
            .clr       (clr[g]),
            .pend      (pend[g])
        );
    end

    // Effective threshold: top of stack, or the base threshold when empty.
    always_comb begin
        lvl = bus.t;
        for (int i = 0; i < Depth; i++)
            if (nest == DepthWidth'(i + 1))
                lvl = stack[i];
    end

    // Strict '>' on the running best keeps the lowest index on ties.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        win_prio = '0;
        for (int i = 0; i < NrSources; i++) begin
            if (pend[i] && bus.e[i] && (bus.prio[i] > lvl) &&
                (!found || (bus.prio[i] > win_prio))) begin
                found    = 1'b1;
                win_idx  = SrcWidth'(i);
                win_prio = bus.prio[i];
            end
        end
    end

    assign is_int  = found && (nest < DepthWidth'(Depth));
    // Complete has priority; a take in the same cycle is dropped.
    assign comp_ok = bus.complete && (nest != '0);
    assign take_ok = bus.take && is_int && !bus.complete;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NrSources; i++)
            clr[i] = take_ok && (win_idx == SrcWidth'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nest <= '0;
            for (int i = 0; i < Depth; i++)
                stack[i] <= '0;
        end else if (comp_ok) begin
            nest <= nest - 1'b1;
        end else if (take_ok) begin
            for (int i = 0; i < Depth; i++)
                if (nest == DepthWidth'(i))
                    stack[i] <= win_prio;
            nest <= nest + 1'b1;
        end
    end

    assign bus.is_interrupt = is_int;
    assign bus.index        = win_idx;
    assign bus.irq_prio     = win_prio;
    assign bus.level        = lvl;
    assign bus.nest         = nest;
endmodule

// File: tb/tb_p_clic_nest.sv
module tb_p_clic_nest;
    localparam int NS    = 4;
    localparam int PW    = 3;
    localparam int DEPTH = 2;
    localparam int PMAX  = (1 << PW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Reference state: pending flags, previous irq, and a queue as the stack.
    bit   m_pend [NS];
    bit   m_prev [NS];
    int   m_stk [$];

    always #5 clk = ~clk;

    p_clic_nest_if #(.NrSources(NS), .PrioWidth(PW), .Depth(DEPTH)) bus ();

    p_clic_nest #(.NrSources(NS), .PrioWidth(PW), .Depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Scan priorities from the top down to just above the threshold; the
    // first enabled pending source met at a level wins (lowest index first).
    task automatic model_eval(output bit is, output int idx, output int pr, output int lvl);
        bit found = 0;
        lvl = (m_stk.size() == 0) ? int'(bus.t) : m_stk[$];
        idx = 0;
        pr  = 0;
        for (int p = PMAX; p > lvl && !found; p--)
            for (int i = 0; i < NS && !found; i++)
                if (m_pend[i] && bus.e[i] && int'(bus.prio[i]) == p) begin
                    found = 1; idx = i; pr = p;
                end
        is = found && (m_stk.size() < DEPTH);
    endtask

    // One clock: compare at negedge, advance the model, return after posedge.
    task automatic step();
        bit is, tk, cp;
        int idx, pr, lvl;
        @(negedge clk);
        model_eval(is, idx, pr, lvl);
        chk("m_isint", bus.is_interrupt, is);
        chk("m_index", bus.index, idx);
        chk("m_prio",  bus.irq_prio, pr);
        chk("m_level", bus.level, lvl);
        chk("m_nest",  bus.nest, m_stk.size());
        if (reset) begin
            for (int i = 0; i < NS; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
            m_stk.delete();
        end else begin
            tk = bus.take && is && !bus.complete;
            cp = bus.complete && (m_stk.size() > 0);
            for (int i = 0; i < NS; i++) begin
                if (bus.edge_mode[i]) begin
                    if (bus.irq[i] && !m_prev[i]) m_pend[i] = 1;
                    else if (tk && idx == i)      m_pend[i] = 0;
                end else begin
                    m_pend[i] = bus.irq[i];
                end
                m_prev[i] = bus.irq[i];
            end
            if (cp)      void'(m_stk.pop_back());
            else if (tk) m_stk.push_back(pr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        bus.irq = m; step(); bus.irq = '0;
        #1;
    endtask

    task automatic do_take();
        bus.take = 1; step(); bus.take = 0;
        #1;
    endtask

    task automatic do_complete();
        bus.complete = 1; step(); bus.complete = 0;
        #1;
    endtask

    task automatic set_prio(input int p0, input int p1, input int p2, input int p3);
        bus.prio[0] = PW'(p0); bus.prio[1] = PW'(p1);
        bus.prio[2] = PW'(p2); bus.prio[3] = PW'(p3);
    endtask

    initial begin
        reset = 1;
        bus.irq = '0; bus.edge_mode = '0; bus.e = '0; bus.t = '0;
        bus.take = 0; bus.complete = 0;
        set_prio(0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset state, held and then released for 5 cycles
        step();
        chk("rst_isint", bus.is_interrupt, 0);
        chk("rst_nest", bus.nest, 0);
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("idle_isint", bus.is_interrupt, 0);
            chk("idle_index", bus.index, 0);
            chk("idle_level", bus.level, 0);
            chk("idle_nest", bus.nest, 0);
        end

        // Single edge request, take, complete
        bus.e = 4'b1111; bus.edge_mode = 4'b0100; bus.t = 1;
        set_prio(1, 1, 3, 1);
        pulse(4'b0100);
        chk("e_isint", bus.is_interrupt, 1);
        chk("e_index", bus.index, 2);
        chk("e_prio", bus.irq_prio, 3);
        do_take();
        chk("e_nest", bus.nest, 1);
        chk("e_level", bus.level, 3);
        chk("e_isint0", bus.is_interrupt, 0);
        do_complete();
        chk("e_lvl_back", bus.level, 1);
        chk("e_nest0", bus.nest, 0);

        // Nesting / preemption
        bus.edge_mode = 4'b1111;
        set_prio(2, 4, 1, 5);
        pulse(4'b0001);
        chk("n_idx0", bus.index, 0);
        do_take();
        pulse(4'b1000);
        chk("n_isint3", bus.is_interrupt, 1);
        chk("n_idx3", bus.index, 3);
        do_take();
        chk("n_nest2", bus.nest, 2);
        chk("n_lvl5", bus.level, 5);
        pulse(4'b0010);
        chk("n_src1_hidden", bus.is_interrupt, 0);
        do_complete();
        chk("n_lvl2", bus.level, 2);
        chk("n_src1_shown", bus.is_interrupt, 1);
        chk("n_idx1", bus.index, 1);
        do_take(); do_complete(); do_complete();
        chk("n_empty", bus.nest, 0);

        // Priority tie
        bus.t = 0;
        set_prio(1, 6, 1, 6);
        pulse(4'b1010);
        chk("tie_idx", bus.index, 1);
        do_take();
        chk("tie_blocked", bus.is_interrupt, 0);
        do_complete();
        chk("tie_idx3", bus.index, 3);
        chk("tie_isint3", bus.is_interrupt, 1);
        do_take(); do_complete();

        // Stack full
        bus.t = 1;
        set_prio(2, 3, 1, 7);
        pulse(4'b0001); do_take();
        pulse(4'b0010); do_take();
        chk("f_nest2", bus.nest, 2);
        pulse(4'b1000);
        chk("f_isint0", bus.is_interrupt, 0);
        do_take();
        chk("f_take_ign", bus.nest, 2);
        do_complete();
        chk("f_nest1", bus.nest, 1);
        chk("f_isint1", bus.is_interrupt, 1);
        chk("f_idx3", bus.index, 3);
        do_take(); do_complete(); do_complete();

        // Take + complete together, then reset mid-nesting
        set_prio(2, 6, 3, 5);
        pulse(4'b0001); do_take();
        pulse(4'b1000);
        chk("tc_idx3", bus.index, 3);
        bus.take = 1; bus.complete = 1; step(); bus.take = 0; bus.complete = 0;
        #1;
        chk("tc_nest0", bus.nest, 0);
        chk("tc_isint", bus.is_interrupt, 1);
        chk("tc_idx", bus.index, 3);
        do_take();
        pulse(4'b0010); do_take();
        chk("r_nest2", bus.nest, 2);
        chk("r_lvl6", bus.level, 6);
        reset = 1; bus.irq = 4'b0100; step();
        reset = 0; bus.irq = '0;
        #1;
        chk("r_nest0", bus.nest, 0);
        chk("r_lvl_t", bus.level, 1);
        chk("r_edge_lost", bus.is_interrupt, 0);
        step();
        chk("r_edge_lost2", bus.is_interrupt, 0);

        // Randomized traffic checked by the reference model
        for (int c = 0; c < 800; c++) begin
            if (c % 25 == 0) begin
                bus.edge_mode = NS'($urandom);
                bus.e = NS'($urandom);
                bus.t = PW'($urandom_range(0, 4));
                for (int i = 0; i < NS; i++) bus.prio[i] = PW'($urandom);
            end
            bus.irq      = NS'($urandom);
            bus.take     = ($urandom_range(0, 1) == 1);
            bus.complete = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 80) == 0);
            step();
        end
        reset = 0; bus.irq = '0; bus.take = 0; bus.complete = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/p_clic_nest.md
# p_clic_nest

Sequential, nesting-capable successor of the combinational CLIC arbiter. It latches per-source interrupt requests in edge- or level-trigger mode and picks the highest-priority enabled pending source above the current threshold. It also runs a claim/complete handshake with the core, keeping a hardware priority stack so that preempting interrupts raise the threshold and completions restore it. It sits between the peripheral interrupt lines and the core's trap logic.

## Interface
- NrSources, 4, number of interrupt sources (≥2)
- PrioWidth, 3, priority/threshold width
- Depth, 4, maximum nesting depth (stack entries, ≥1)
- SrcWidth, $clog2(NrSources), derived index width (localparam)
- DepthWidth, $clog2(Depth+1), derived stack-count width (localparam)
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- irq  in  NrSources  raw interrupt request lines
- edge_mode  in  NrSources  per source: 1 = rising-edge triggered, 0 = level triggered
- e  in  NrSources  per-source enable
- prio  in  PrioWidth × NrSources (unpacked array [NrSources])  per-source priority
- t  in  PrioWidth  base threshold, used when stack is empty
- take  in  1  core claims the presented interrupt
- complete  in  1  core finishes the innermost active interrupt
- is_interrupt  out  1  a claimable interrupt is presented
- index  out  SrcWidth  winning source index
- irq_prio  out  PrioWidth  winning source priority
- level  out  PrioWidth  current effective threshold
- nest  out  DepthWidth  number of stacked (active) interrupts

## Operation
- State: pend[NrSources], irq_q[NrSources] (previous irq for edge detection), stack of Depth priority entries, count nest.
- Pending update, every cycle:
  - level source: pend[i] <= irq[i]
  - edge source: set on irq[i] & ~irq_q[i]; cleared when that source is taken; set wins over clear in the same cycle.
- Effective threshold: level = t when nest==0, else stack[nest-1].
- Arbitration is combinational from registered state.
  - Candidate i requires pend[i] & e[i] & (prio[i] > level), compared unsigned.
  - Winner is the highest prio; ties go to the lowest index.
  - is_interrupt = any candidate & (nest < Depth).
  - With no candidate: index = 0 and irq_prio = 0.
- take, accepted only when is_interrupt==1 and complete==0:
  - push irq_prio; nest += 1
  - clear pend[index] if that source is edge mode
- complete, accepted only when nest>0: pop; nest -= 1.
  - complete with nest==0 is ignored.
- take and complete in the same cycle: complete is processed, take is ignored (the core re-claims).
- take while is_interrupt==0 is ignored.
- Stack full (nest==Depth): is_interrupt forced 0 regardless of candidates; complete still accepted.
- Changes to e, prio or t take effect combinationally on the outputs in the same cycle.
- The stack content is not rewritten by t changes.

## Timing
- Reset values: pend=0, irq_q=0, nest=0, stack=0.
  - Outputs during and after reset: is_interrupt=0, index=0, irq_prio=0, level=t, nest=0.
- Request latency: irq rises in cycle N → pend set at end of N → is_interrupt=1 in cycle N+1.
- Accepted take in cycle N → from N+1:
  - nest incremented
  - level = taken prio
  - the taken edge source is no longer pending
- Accepted complete in cycle N → from N+1: nest decremented and level restored to the previous entry or t.
- Reset asserted mid-nesting clears the stack and pending state at that edge.
  - Edge requests whose rising edge coincided with the reset cycle are lost.
- A level source remains pending while irq is high, even after being taken.
  - It re-presents only if its prio exceeds level.

## Test plan
- Reset, all irq=0, t=0 → is_interrupt=0, index=0, level=0, nest=0; remains so for 5 cycles.
- Edge src 2 prio 3, t=1, pulse irq[2] one cycle N → is_interrupt=1, index=2, irq_prio=3 at N+1; take at N+1 → nest=1, level=3, is_interrupt=0 at N+2; complete → level=1, nest=0.
- Nesting: src 0 prio 2 taken, then src 3 prio 5 asserted → presented and taken, nest=2, level=5; src 1 prio 4 asserted → not presented; complete → level=2, src 1 presented with index=1.
- Tie: srcs 1 and 3 both prio 6, pending, t=0 → index=1; after take of 1 (edge mode), src 3 not presented (6 not > 6) until complete.
- Depth=2 full: two nested takes → nest=2; higher-prio request → is_interrupt=0; take ignored; complete → nest=1 and request presented next cycle.
- Simultaneous take+complete with nest=1 → nest=0, winner still pending and presented the next cycle; reset asserted with nest=2 → nest=0, level=t next cycle.
